// File: rtl/pattern_detector_param.sv
// Configurable serial pattern detector with a don't-care mask, selectable overlap,
// a registered match pulse and a saturating match counter.
module pattern_detector_param #(
    parameter int SYM_W   = 1,
    parameter int PAT_LEN = 5,
    parameter int CNT_W   = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [SYM_W-1:0]         d_in,
    input  logic                     valid_in,
    input  logic                     cfg_load,
    input  logic [PAT_LEN*SYM_W-1:0] cfg_pattern,
    input  logic [PAT_LEN-1:0]       cfg_mask,
    input  logic                     cfg_overlap,
    input  logic                     clr_count,
    output logic                     pattern_flag,
    output logic [CNT_W-1:0]         match_count,
    output logic                     armed
);

    localparam int HIST_W = PAT_LEN * SYM_W;
    localparam int FILL_W = $clog2(PAT_LEN + 1);
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_LEN);
    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [HIST_W-1:0]   hist_q, hist_d;
    logic [FILL_W-1:0]   fill_q, fill_d;
    logic [HIST_W-1:0]   pat_q, pat_d;
    logic [PAT_LEN-1:0]  mask_q, mask_d;
    logic                ovl_q, ovl_d;
    logic                flag_q, flag_d;
    logic [CNT_W-1:0]    count_q, count_d;

    logic [HIST_W-1:0]   hist_shift;
    logic [FILL_W-1:0]   fill_inc;
    logic                hit;
    logic                accept;
    logic                match;

    // NOTE: every variable gets a default before any branch so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        hist_d  = hist_q;
        fill_d  = fill_q;
        pat_d   = pat_q;
        mask_d  = mask_q;
        ovl_d   = ovl_q;
        count_d = count_q;

        // Newest symbol enters at the top; index 0 holds the oldest.
        hist_shift = {d_in, hist_q[HIST_W-1:SYM_W]};
        fill_inc   = (fill_q == FILL_FULL) ? fill_q : fill_q + 1'b1;

        hit = 1'b1;
        for (int i = 0; i < PAT_LEN; i++) begin
            if (mask_q[i] && (hist_shift[i*SYM_W +: SYM_W] != pat_q[i*SYM_W +: SYM_W])) begin
                hit = 1'b0;
            end
        end

        accept = (state_q == RUN) && valid_in && !cfg_load;
        match  = accept && (fill_inc == FILL_FULL) && hit;
        flag_d = match;

        if (cfg_load) begin
            state_d = RUN;
            pat_d   = cfg_pattern;
            mask_d  = cfg_mask;
            ovl_d   = cfg_overlap;
            hist_d  = '0;
            fill_d  = '0;
        end else if (accept) begin
            hist_d = hist_shift;
            fill_d = (match && !ovl_q) ? '0 : fill_inc;
        end

        if (clr_count) begin
            count_d = match ? CNT_W'(1) : '0;
        end else if (match && (count_q != CNT_MAX)) begin
            count_d = count_q + 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            hist_q  <= '0;
            fill_q  <= '0;
            pat_q   <= '0;
            mask_q  <= '1;
            ovl_q   <= 1'b0;
            flag_q  <= 1'b0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            hist_q  <= hist_d;
            fill_q  <= fill_d;
            pat_q   <= pat_d;
            mask_q  <= mask_d;
            ovl_q   <= ovl_d;
            flag_q  <= flag_d;
            count_q <= count_d;
        end
    end

    assign pattern_flag = flag_q;
    assign match_count  = count_q;
    assign armed        = (state_q == RUN);

endmodule

// File: tb/tb_pattern_detector_param.sv
// Scoreboard bench: directed vectors push expected outputs; a negedge monitor pops and compares.
module tb_pattern_detector_param;

    logic       clk = 1'b0;
    logic       reset;
    logic [0:0] d_in;
    logic       valid_in;
    logic       cfg_load;
    logic [4:0] cfg_pattern;
    logic [4:0] cfg_mask;
    logic       cfg_overlap;
    logic       clr_count;
    logic       pattern_flag, pattern_flag2;
    logic [7:0] match_count;
    logic [1:0] match_count2;
    logic       armed, armed2;

    always #5 clk = ~clk;

    pattern_detector_param u_dut (
        .clk(clk), .reset(reset), .d_in(d_in), .valid_in(valid_in),
        .cfg_load(cfg_load), .cfg_pattern(cfg_pattern), .cfg_mask(cfg_mask),
        .cfg_overlap(cfg_overlap), .clr_count(clr_count),
        .pattern_flag(pattern_flag), .match_count(match_count), .armed(armed)
    );

    pattern_detector_param #(.SYM_W(1), .PAT_LEN(5), .CNT_W(2)) u_dut2 (
        .clk(clk), .reset(reset), .d_in(d_in), .valid_in(valid_in),
        .cfg_load(cfg_load), .cfg_pattern(cfg_pattern), .cfg_mask(cfg_mask),
        .cfg_overlap(cfg_overlap), .clr_count(clr_count),
        .pattern_flag(pattern_flag2), .match_count(match_count2), .armed(armed2)
    );

    typedef struct packed {
        logic        flag;
        logic [7:0]  cnt;
        logic        armed;
        logic        chk2;
        logic [1:0]  cnt2;
        logic [15:0] id;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_bad = 0;
    int   vec_id = 0;
    logic exp_armed = 1'b0;

    // Monitor: one expected entry per clocked vector, compared mid-cycle.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            logic bad;
            e = exp_q.pop_front();
            n_vec++;
            bad = (pattern_flag !== e.flag) || (match_count !== e.cnt) || (armed !== e.armed)
                  || (e.chk2 && (match_count2 !== e.cnt2));
            if (bad) begin
                n_bad++;
                $display("FAIL vec%0d: got flag=%b cnt=%0d armed=%b cnt2=%0d, want flag=%b cnt=%0d armed=%b cnt2=%0d(chk=%b)",
                         e.id, pattern_flag, match_count, armed, match_count2,
                         e.flag, e.cnt, e.armed, e.cnt2, e.chk2);
            end
        end
    end

    task automatic step(input logic v, input logic d, input logic ld, input logic clr,
                        input logic ef, input int ec, input int ec2);
        exp_t e;
        @(negedge clk);
        valid_in  = v;
        d_in      = d;
        cfg_load  = ld;
        clr_count = clr;
        @(posedge clk);
        #1;
        valid_in  = 1'b0;
        cfg_load  = 1'b0;
        clr_count = 1'b0;
        e.flag  = ef;
        e.cnt   = 8'(ec);
        e.armed = exp_armed;
        e.chk2  = (ec2 >= 0);
        e.cnt2  = 2'(ec2);
        e.id    = 16'(vec_id);
        vec_id++;
        exp_q.push_back(e);
    endtask

    task automatic sym(input logic d, input logic ef, input int ec, input int ec2 = -1);
        step(1'b1, d, 1'b0, 1'b0, ef, ec, ec2);
    endtask

    task automatic gap(input int ec);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, ec, -1);
    endtask

    task automatic load(input logic [4:0] p, input logic [4:0] m, input logic o,
                        input int ec, input int ec2 = -1);
        cfg_pattern = p;
        cfg_mask    = m;
        cfg_overlap = o;
        exp_armed   = 1'b1;
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, ec, ec2);
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && exp_q.size() > 0; i++) begin
            @(negedge clk);
            #1;
        end
        if (exp_q.size() > 0) begin
            n_bad++;
            $display("FAIL drain: %0d entries left, want 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic check_now(input string name, input logic [7:0] want_cnt);
        n_vec++;
        if (pattern_flag !== 1'b0 || match_count !== want_cnt || armed !== 1'b0
            || match_count2 !== 2'd0) begin
            n_bad++;
            $display("FAIL %s: got flag=%b cnt=%0d armed=%b cnt2=%0d, want 0/%0d/0/0",
                     name, pattern_flag, match_count, armed, match_count2, want_cnt);
        end
    endtask

    initial begin
        reset = 1'b1; d_in = '0; valid_in = 1'b0; cfg_load = 1'b0;
        cfg_pattern = '0; cfg_mask = '0; cfg_overlap = 1'b0; clr_count = 1'b0;
        #2;
        check_now("reset_state", 8'd0);
        @(negedge clk);
        reset = 1'b0;

        // Symbols before any configuration are ignored.
        sym(1, 0, 0); sym(0, 0, 0);

        // BBCBC, non-overlapping.
        load(5'b01011, 5'b11111, 1'b0, 0);
        sym(1, 0, 0); sym(1, 0, 0); sym(0, 0, 0); sym(1, 0, 0); sym(0, 1, 1);

        // Same pattern with idle gaps between symbols.
        sym(1, 0, 1); gap(1); sym(1, 0, 1); gap(1); sym(0, 0, 1); gap(1);
        sym(1, 0, 1); gap(1); sym(0, 1, 2); gap(2);

        // 10101 with overlap: matches after symbols 5 and 7.
        load(5'b10101, 5'b11111, 1'b1, 2);
        sym(1, 0, 2); sym(0, 0, 2); sym(1, 0, 2); sym(0, 0, 2); sym(1, 1, 3);
        sym(0, 0, 3); sym(1, 1, 4);

        // 10101 without overlap: only symbol 5 matches.
        load(5'b10101, 5'b11111, 1'b0, 4);
        sym(1, 0, 4); sym(0, 0, 4); sym(1, 0, 4); sym(0, 0, 4); sym(1, 1, 5);
        sym(0, 0, 5); sym(1, 0, 5);

        // Symbol 1 don't-care matches 1,0,0,1,0; full mask does not.
        load(5'b01011, 5'b11101, 1'b0, 5);
        sym(1, 0, 5); sym(0, 0, 5); sym(0, 0, 5); sym(1, 0, 5); sym(0, 1, 6);
        load(5'b01011, 5'b11111, 1'b0, 6);
        sym(1, 0, 6); sym(0, 0, 6); sym(0, 0, 6); sym(1, 0, 6); sym(0, 0, 6);

        // All-zero mask with overlap matches every symbol once full.
        load(5'b01011, 5'b00000, 1'b1, 6);
        sym(0, 0, 6); sym(1, 0, 6); sym(1, 0, 6); sym(0, 0, 6);
        sym(1, 1, 7); sym(0, 1, 8); sym(1, 1, 9);

        // cfg_load coinciding with the completing symbol drops it and clears history.
        load(5'b01011, 5'b11111, 1'b0, 9);
        sym(1, 0, 9); sym(1, 0, 9); sym(0, 0, 9); sym(1, 0, 9);
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 9, -1);
        sym(0, 0, 9);
        sym(1, 0, 9); sym(1, 0, 9); sym(0, 0, 9); sym(1, 0, 9); sym(0, 1, 10);

        // clr_count alone, then saturation on the 2-bit counter with a coincident clear.
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0, 0);
        load(5'b01011, 5'b00000, 1'b1, 0, 0);
        sym(1, 0, 0, 0); sym(1, 0, 0, 0); sym(1, 0, 0, 0); sym(1, 0, 0, 0);
        sym(1, 1, 1, 1); sym(1, 1, 2, 2); sym(1, 1, 3, 3);
        step(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1, 1);
        sym(1, 1, 2, 2); sym(1, 1, 3, 3); sym(1, 1, 4, 3); sym(1, 1, 5, 3);

        // Reset in the middle of a partial match.
        load(5'b01011, 5'b11111, 1'b0, 5, 3);
        sym(1, 0, 5, 3); sym(1, 0, 5, 3); sym(0, 0, 5, 3);
        drain();
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        check_now("async_reset", 8'd0);
        exp_armed = 1'b0;
        #1;
        reset = 1'b0;
        sym(1, 0, 0, 0); sym(0, 0, 0, 0);
        load(5'b01011, 5'b11111, 1'b0, 0, 0);
        sym(1, 0, 0, 0); sym(1, 0, 0, 0); sym(0, 0, 0, 0); sym(1, 0, 0, 0);
        sym(0, 1, 1, 1);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
